// File: rtl/nbody_pkg.sv
// Shared types, widths and the DATA_W saturation helper for the n-body Verlet accumulator.
package nbody_pkg;
  localparam int PKG_DATA_W = 32;
  localparam int PKG_FRAC_W = 16;
  localparam int PKG_ACC_W  = 40;

  typedef logic signed [PKG_DATA_W-1:0] fxp_t;
  typedef logic signed [PKG_ACC_W-1:0]  acc_t;

  typedef enum logic [2:0] {ST_ACCUM, ST_MUL_A, ST_MUL_Q, ST_EMIT, ST_DONE} state_e;

  // Clamp any value carried in an accumulator-wide word to the signed DATA_W range.
  function automatic fxp_t sat_to_fxp(input acc_t v);
    logic fits;
    fits = (v[PKG_ACC_W-1:PKG_DATA_W-1] == {(PKG_ACC_W-PKG_DATA_W+1){v[PKG_ACC_W-1]}});
    if (fits)                return v[PKG_DATA_W-1:0];
    else if (v[PKG_ACC_W-1]) return {1'b1, {(PKG_DATA_W-1){1'b0}}};
    else                     return {1'b0, {(PKG_DATA_W-1){1'b1}}};
  endfunction
endpackage

// File: rtl/nbody_verlet_accumulator_mul.sv
// Signed fixed-point multiply, arithmetic shift by FRAC_W, saturate to DATA_W.
module nbody_fxp_mul_sat import nbody_pkg::*; #(
  parameter int DATA_W = PKG_DATA_W,
  parameter int FRAC_W = PKG_FRAC_W
) (
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  output logic signed [DATA_W-1:0] p_o
);
  logic signed [2*DATA_W-1:0] prod, shr;
  logic                       ovf;

  assign prod = a_i * b_i;
  assign shr  = prod >>> FRAC_W;
  assign ovf  = (shr[2*DATA_W-1:DATA_W-1] != {(DATA_W+1){shr[2*DATA_W-1]}});
  assign p_o  = !ovf ? shr[DATA_W-1:0] :
                shr[2*DATA_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
endmodule

// File: rtl/nbody_verlet_accumulator.sv
// Net-force accumulation followed by sequential Verlet integration over all bodies.
// NBODY_ACC_SAT_EN: accumulator adds saturate to the ACC_W range instead of wrapping.
module nbody_verlet_accumulator import nbody_pkg::*; #(
  parameter int N_BODIES = 4,
  parameter int DATA_W   = PKG_DATA_W,
  parameter int FRAC_W   = PKG_FRAC_W,
  parameter int ACC_W    = PKG_ACC_W,
  parameter int IDX_W    = $clog2(N_BODIES)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cfg_we,
  input  logic [IDX_W-1:0]         cfg_idx,
  input  logic signed [DATA_W-1:0] cfg_q,
  input  logic signed [DATA_W-1:0] cfg_q_old,
  input  logic signed [DATA_W-1:0] cfg_inv_m,
  input  logic signed [DATA_W-1:0] dt2,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IDX_W-1:0]         in_idx,
  input  logic signed [DATA_W-1:0] in_force,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IDX_W-1:0]         out_idx,
  output logic signed [DATA_W-1:0] out_q,
  output logic                     step_done,
  output logic                     err_idx
);
  localparam logic [IDX_W:0] NB = (IDX_W+1)'(N_BODIES);

  state_e                   state_q;
  logic [IDX_W-1:0]         k_q, out_idx_q;
  logic                     out_valid_q, step_done_q, err_q;
  logic signed [DATA_W-1:0] dt2_q, a_q, out_q_q;
  logic signed [ACC_W-1:0]  acc_q     [N_BODIES];
  logic signed [DATA_W-1:0] pos_q     [N_BODIES];
  logic signed [DATA_W-1:0] pos_old_q [N_BODIES];
  logic signed [DATA_W-1:0] inv_m_q   [N_BODIES];

  logic                     in_bad, cfg_bad;
  logic signed [ACC_W-1:0]  acc_k, acc_in, acc_d, force_ext;
  logic signed [DATA_W-1:0] pos_k, pos_old_k, inv_m_k;
  logic signed [DATA_W-1:0] mul_a, mul_b, mul_p, q_new;
  logic signed [DATA_W+1:0] q_sum;

  assign in_bad    = {1'b0, in_idx}  >= NB;
  assign cfg_bad   = {1'b0, cfg_idx} >= NB;
  assign in_ready  = (state_q == ST_ACCUM);
  assign out_valid = out_valid_q;
  assign out_idx   = out_idx_q;
  assign out_q     = out_q_q;
  assign step_done = step_done_q;
  assign err_idx   = err_q;

  always_comb begin
    acc_k = '0; acc_in = '0; pos_k = '0; pos_old_k = '0; inv_m_k = '0;
    for (int i = 0; i < N_BODIES; i++) begin
      if (k_q == IDX_W'(i)) begin
        acc_k = acc_q[i]; pos_k = pos_q[i]; pos_old_k = pos_old_q[i]; inv_m_k = inv_m_q[i];
      end
      if (in_idx == IDX_W'(i)) acc_in = acc_q[i];
    end
  end

  assign force_ext = {{(ACC_W-DATA_W){in_force[DATA_W-1]}}, in_force};
`ifdef NBODY_ACC_SAT_EN
  logic signed [ACC_W:0] acc_wide;
  assign acc_wide = {acc_in[ACC_W-1], acc_in} + {force_ext[ACC_W-1], force_ext};
  always_comb begin
    if (acc_wide[ACC_W] != acc_wide[ACC_W-1])
      acc_d = acc_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      acc_d = acc_wide[ACC_W-1:0];
  end
`else
  assign acc_d = acc_in + force_ext;
`endif

  // One multiplier: acc*inv_m in MUL_A, dt2*a in MUL_Q.
  assign mul_a = (state_q == ST_MUL_A) ? sat_to_fxp(acc_k) : dt2_q;
  assign mul_b = (state_q == ST_MUL_A) ? inv_m_k : a_q;

  nbody_fxp_mul_sat #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_p)
  );

  assign q_sum = {pos_k[DATA_W-1], pos_k, 1'b0}
               - {{2{pos_old_k[DATA_W-1]}}, pos_old_k}
               + {{2{mul_p[DATA_W-1]}}, mul_p};
  assign q_new = sat_to_fxp({{(ACC_W-DATA_W-2){q_sum[DATA_W+1]}}, q_sum});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_ACCUM;
      k_q         <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      step_done_q <= 1'b0;
      err_q       <= 1'b0;
      dt2_q       <= '0;
      a_q         <= '0;
      out_q_q     <= '0;
      for (int i = 0; i < N_BODIES; i++) begin
        acc_q[i] <= '0; pos_q[i] <= '0; pos_old_q[i] <= '0; inv_m_q[i] <= '0;
      end
    end else begin
      step_done_q <= 1'b0;
      case (state_q)
        ST_ACCUM: begin
          if (cfg_we) begin
            if (cfg_bad) err_q <= 1'b1;
            for (int i = 0; i < N_BODIES; i++)
              if (cfg_idx == IDX_W'(i)) begin
                pos_q[i] <= cfg_q; pos_old_q[i] <= cfg_q_old; inv_m_q[i] <= cfg_inv_m;
              end
          end
          if (in_valid) begin
            if (in_bad) err_q <= 1'b1;
            for (int i = 0; i < N_BODIES; i++)
              if (in_idx == IDX_W'(i)) acc_q[i] <= acc_d;
            if (in_last) begin
              dt2_q   <= dt2;
              k_q     <= '0;
              state_q <= ST_MUL_A;
            end
          end
        end
        ST_MUL_A: begin
          a_q     <= mul_p;
          state_q <= ST_MUL_Q;
        end
        ST_MUL_Q: begin
          out_q_q     <= q_new;
          out_idx_q   <= k_q;
          out_valid_q <= 1'b1;
          state_q     <= ST_EMIT;
        end
        ST_EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            for (int i = 0; i < N_BODIES; i++)
              if (k_q == IDX_W'(i)) begin
                pos_old_q[i] <= pos_q[i]; pos_q[i] <= out_q_q; acc_q[i] <= '0;
              end
            if (k_q == IDX_W'(N_BODIES-1)) begin
              step_done_q <= 1'b1;
              state_q     <= ST_DONE;
            end else begin
              k_q     <= k_q + IDX_W'(1);
              state_q <= ST_MUL_A;
            end
          end
        end
        ST_DONE:  state_q <= ST_ACCUM;
        default:  state_q <= ST_ACCUM;
      endcase
    end
  end
endmodule
